// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer: paces 8 light steps, holds for an LFSR-random delay, clears the lights
// and measures reaction time. Define F1_JUMP_START_EN to abort the sequence on a false start.
module f1_start_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned LFSR_W   = 7,
  parameter int unsigned RT_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trigger_i,
  input  logic            react_i,
  output logic            step_en_o,
  output logic            seq_clr_o,
  output logic            lights_out_o,
  output logic            busy_o,
  output logic [RT_W-1:0] react_time_o,
  output logic            react_valid_o,
  output logic            jump_start_o
);

  localparam int unsigned PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, TIMING} state_e;

  state_e            state_q, state_d;
  logic [PS_W-1:0]   prescale_q, prescale_d;
  logic [2:0]        step_cnt_q, step_cnt_d;
  logic [LFSR_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [RT_W-1:0]   react_cnt_q, react_cnt_d;
  logic [RT_W-1:0]   react_time_q, react_time_d;
  logic              react_valid_q, react_valid_d;
  logic              tick;
  logic              step_en, seq_clr, lights_out;
`ifdef F1_JUMP_START_EN
  logic              jump_start;
`endif

  assign tick = (prescale_q == PS_W'(TICK_DIV - 1));

  always_comb begin
    // NOTE: every signal gets its default first; a path that leaves one unassigned infers a latch.
    state_d       = state_q;
    prescale_d    = prescale_q;
    step_cnt_d    = step_cnt_q;
    delay_cnt_d   = delay_cnt_q;
    react_cnt_d   = react_cnt_q;
    react_time_d  = react_time_q;
    react_valid_d = 1'b0;
    step_en       = 1'b0;
    seq_clr       = 1'b0;
    lights_out    = 1'b0;
    // x^7 + x^3 + 1, runs in every state so the hold delay depends on when the trigger lands
    lfsr_d        = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[2]};

    case (state_q)
      IDLE: begin
        prescale_d = '0;
        if (trigger_i) begin
          seq_clr    = 1'b1;
          state_d    = FILL;
          step_cnt_d = '0;
        end
      end
      FILL: begin
        prescale_d = tick ? '0 : prescale_q + PS_W'(1);
        if (tick) begin
          step_en    = 1'b1;
          step_cnt_d = step_cnt_q + 3'd1;
          if (step_cnt_q == 3'd7) begin
            state_d     = HOLD;
            delay_cnt_d = lfsr_q;
          end
        end
      end
      HOLD: begin
        prescale_d = tick ? '0 : prescale_q + PS_W'(1);
        if (tick) begin
          delay_cnt_d = delay_cnt_q - LFSR_W'(1);
          if (delay_cnt_q == LFSR_W'(1)) begin
            step_en     = 1'b1;
            lights_out  = 1'b1;
            state_d     = TIMING;
            react_cnt_d = '0;
          end
        end
      end
      TIMING: begin
        prescale_d  = '0;
        react_cnt_d = (&react_cnt_q) ? react_cnt_q : react_cnt_q + RT_W'(1);
        if (react_i) begin
          react_time_d  = react_cnt_q;
          react_valid_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef F1_JUMP_START_EN
    // A false start overrides everything, including a coinciding final hold tick.
    jump_start = 1'b0;
    if ((state_q == FILL || state_q == HOLD) && react_i) begin
      jump_start  = 1'b1;
      seq_clr     = 1'b1;
      step_en     = 1'b0;
      lights_out  = 1'b0;
      state_d     = IDLE;
      prescale_d  = '0;
      step_cnt_d  = step_cnt_q;
      delay_cnt_d = delay_cnt_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is small control state, so all of it takes the async reset.
      state_q       <= IDLE;
      prescale_q    <= '0;
      step_cnt_q    <= '0;
      delay_cnt_q   <= '0;
      lfsr_q        <= LFSR_W'(1);
      react_cnt_q   <= '0;
      react_time_q  <= '0;
      react_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q       <= state_d;
      prescale_q    <= prescale_d;
      step_cnt_q    <= step_cnt_d;
      delay_cnt_q   <= delay_cnt_d;
      lfsr_q        <= lfsr_d;
      react_cnt_q   <= react_cnt_d;
      react_time_q  <= react_time_d;
      react_valid_q <= react_valid_d;
    end
  end

  assign step_en_o     = step_en;
  assign seq_clr_o     = seq_clr;
  assign lights_out_o  = lights_out;
  assign busy_o        = (state_q != IDLE);
  assign react_time_o  = react_time_q;
  assign react_valid_o = react_valid_q;
`ifdef F1_JUMP_START_EN
  assign jump_start_o  = jump_start;
`else
  assign jump_start_o  = 1'b0;
`endif

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Bench for f1_start_ctrl: a timeline model (event cycles computed from the trigger cycle and the
// modelled LFSR) is compared against the DUT every cycle, plus literal checks from the stimulus.
module tb_f1_start_ctrl;

  localparam int DIV   = 4;
  localparam int NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic        react = 1'b0;
  logic        step_en, seq_clr, lights_out, busy, react_valid, jump_start;
  logic [15:0] react_time;

  f1_start_ctrl #(.TICK_DIV(DIV), .LFSR_W(7), .RT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger_i    (trigger),
    .react_i      (react),
    .step_en_o    (step_en),
    .seq_clr_o    (seq_clr),
    .lights_out_o (lights_out),
    .busy_o       (busy),
    .react_time_o (react_time),
    .react_valid_o(react_valid),
    .jump_start_o (jump_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[2]};
  endfunction

  function automatic logic [6:0] lfsr_adv(input logic [6:0] v, input int n);
    logic [6:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = lfsr_next(r);
    return r;
  endfunction

  // Light register driven by the DUT pulses.
  logic [7:0] light;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       light <= 8'h00;
    else if (seq_clr) light <= 8'h00;
    else if (step_en) light <= (light == 8'hFF) ? 8'h00 : {light[6:0], 1'b1};
  end

  // Timeline model: a sequence accepted at cycle t0 steps at t0+k*DIV (k=1..8), goes dark at
  // lo = t0 + 8*DIV + DIV*D, and a reaction at cycle r reports r-lo-1 (saturated).
  int          cyc    = 0;
  bit          m_act  = 1'b0;
  int          m_t0   = 0;
  int          m_lo   = NEVER;
  logic [6:0]  m_lfsr = 7'd1;
  logic [15:0] m_rt   = 16'd0;
  bit          m_rv   = 1'b0;
  int          d_last = 0;
  bit          js_en;

  initial begin
`ifdef F1_JUMP_START_EN
    js_en = 1'b1;
`else
    js_en = 1'b0;
`endif
  end

  always @(negedge clk) begin : model_b
    bit idle, in_seq, timing, jmp, e_step, e_lo, e_clr;
    int dt;
    if (!rst_n) begin
      m_act = 1'b0; m_lfsr = 7'd1; m_rt = 16'd0; m_rv = 1'b0; m_lo = NEVER; cyc = 0;
      check("reset busy", busy, 0);
      check("reset step_en", step_en, 0);
      check("reset lights_out", lights_out, 0);
      check("reset react_time", react_time, 0);
      check("reset react_valid", react_valid, 0);
      check("reset jump_start", jump_start, 0);
    end else begin
      idle   = !m_act;
      in_seq = m_act && cyc > m_t0 && cyc <= m_lo;
      timing = m_act && cyc > m_lo;
      jmp    = js_en && in_seq && react;
      dt     = cyc - m_t0;
      e_step = in_seq && !jmp && (((dt % DIV) == 0 && dt <= 8 * DIV) || cyc == m_lo);
      e_lo   = in_seq && !jmp && cyc == m_lo;
      e_clr  = (idle && trigger) || jmp;
      check("model step_en", step_en, e_step);
      check("model lights_out", lights_out, e_lo);
      check("model seq_clr", seq_clr, e_clr);
      check("model jump_start", jump_start, jmp);
      check("model busy", busy, m_act);
      check("model react_valid", react_valid, m_rv);
      check("model react_time", react_time, m_rt);
      m_rv = 1'b0;
      if (idle) begin
        if (trigger) begin m_act = 1'b1; m_t0 = cyc; m_lo = NEVER; end
      end else if (jmp) begin
        m_act = 1'b0;
      end else if (in_seq && dt == 8 * DIV) begin
        d_last = int'(m_lfsr);
        m_lo   = cyc + DIV * int'(m_lfsr);
      end else if (timing && react) begin
        m_rt  = (cyc - m_lo - 1 > 65535) ? 16'hFFFF : 16'(cyc - m_lo - 1);
        m_rv  = 1'b1;
        m_act = 1'b0;
      end
      m_lfsr = lfsr_next(m_lfsr);
      cyc++;
    end
  end

  // Waits (bounded) for a pulse; sel 0=step_en 1=lights_out 2=react_valid. n = negedges waited.
  task automatic wait_pulse(input string name, input int sel, input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       seen = step_en;
        1:       seen = lights_out;
        default: seen = react_valid;
      endcase
    end
    check($sformatf("%s seen", name), seen, 1);
  endtask

  task automatic start_seq();
    trigger = 1'b1;
    @(negedge clk);
    check("seq_clr on trigger", seq_clr, 1);
    check("busy before fill", busy, 0);
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  task automatic fill_steps(input int count, input int first_gap);
    int n;
    for (int i = 0; i < count; i++) begin
      wait_pulse("step_en", 0, 2 * DIV, n);
      check("step spacing", n, (i == 0) ? first_gap : DIV);
    end
  endtask

  task automatic finish_seq(input int rdelay, input bit trig_noise, output int d);
    int n;
    @(posedge clk); #1;
    check("light full", light, 8'hFF);
    trigger = trig_noise;
    wait_pulse("lights_out", 1, DIV * 128 + 4, n);
    check("hold length", n, DIV * d_last);
    check("9th step_en", step_en, 1);
    d = d_last;
    @(posedge clk); #1 trigger = 1'b0;
    check("light cleared", light, 8'h00);
    repeat (rdelay) @(posedge clk);
    #1 react = 1'b1;
    wait_pulse("react_valid", 2, 4, n);
    check("react_time", react_time, (rdelay > 65535) ? 32'hFFFF : rdelay);
    check("idle after react", busy, 0);
    @(posedge clk); #1 react = 1'b0;
  endtask

  initial begin : stim
    int n, d, steps, busy_seen, valid_seen;
    logic [15:0] rt_before;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    steps = 0; busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      react = 1'($urandom_range(0, 1));
      @(negedge clk);
      steps += int'(step_en);
      busy_seen |= int'(busy);
      @(posedge clk); #1;
    end
    react = 1'b0;
    check("idle step_en count", steps, 0);
    check("idle busy", busy_seen, 0);
    check("idle react_time", react_time, 0);

    start_seq(); fill_steps(8, DIV); finish_seq(37, 1'b0, d);

    n = 0;
    while (lfsr_adv(m_lfsr, 8 * DIV) != 7'd1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    start_seq(); fill_steps(8, DIV); finish_seq(0, 1'b1, d);
    check("forced D", d, 1);

    start_seq(); fill_steps(8, DIV); finish_seq(70000, 1'b0, d);

    rt_before = react_time;
    start_seq(); fill_steps(3, DIV);
    @(posedge clk); #1 react = 1'b1;
    @(negedge clk);
    check("step_en during react", step_en, 0);
`ifdef F1_JUMP_START_EN
    check("jump_start", jump_start, 1);
    check("seq_clr on jump", seq_clr, 1);
    @(posedge clk); #1 react = 1'b0;
    check("abort idle", busy, 0);
    steps = 0; valid_seen = 0;
    repeat (40) begin
      @(negedge clk);
      steps += int'(step_en);
      valid_seen |= int'(react_valid);
    end
    check("steps after abort", steps, 0);
    check("valid after abort", valid_seen, 0);
    check("react_time kept", react_time, rt_before);
    @(posedge clk); #1;
`else
    check("no jump_start", jump_start, 0);
    check("no seq_clr", seq_clr, 0);
    @(posedge clk); #1 react = 1'b0;
    check("still busy", busy, 1);
    fill_steps(5, DIV - 1);
    finish_seq(5, 1'b0, d);
`endif

    start_seq(); fill_steps(8, DIV);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("busy on async reset", busy, 0);
    check("light on async reset", light, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_seq(); fill_steps(8, DIV); finish_seq($urandom_range(1, 50), 1'b0, d);

    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 20)) begin
        react = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      react = 1'b0;
      start_seq(); fill_steps(8, DIV);
      finish_seq($urandom_range(0, 300), 1'($urandom_range(0, 1)), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #950000;
    total++;
    bad++;
    $display("FAIL watchdog: run still going at %0t, limit 950000", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/f1_start_ctrl.md
Name: f1_start_ctrl

Overview:
- Sequencer for the F1 start-light register (8-bit fill-with-ones shift register that steps on `en` and wraps 0xFF->0x00).
- Accepts a start trigger and paces 8 light steps at a fixed tick rate.
- Holds all lights on for a pseudo-random number of ticks, then issues the 9th step that clears them ("lights out").
- Measures the driver's reaction time in clock cycles.

Parameters:
- TICK_DIV, 4, clock cycles per tick; must be >= 2.
- LFSR_W, 7, width of the random-delay LFSR (taps x^7 + x^3 + 1).
- RT_W, 16, width of the reaction-time counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- trigger  in  1  start request; level-sampled, acted on only in IDLE.
- react  in  1  driver button; level-sampled.
- step_en  out  1  one-cycle pulse to the light register enable.
- seq_clr  out  1  one-cycle pulse to the light register reset.
- lights_out  out  1  one-cycle pulse, coincident with the 9th step_en.
- busy  out  1  high when state != IDLE.
- react_time  out  RT_W  last measured reaction time, in cycles.
- react_valid  out  1  one-cycle pulse when react_time updates.
- jump_start  out  1  one-cycle pulse on a false start; tied 0 when the optional feature is out.

Behaviour:
- Reset (rst_n low, async): state=IDLE, prescaler=0, step_cnt=0, delay_cnt=0, react_cnt=0, react_time=0, lfsr=1. All pulse outputs and busy are 0.
- LFSR:
  - Free-runs: shifts every clk cycle in every state; never reaches 0.
  - Sampled into delay_cnt on the HOLD entry edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 in FILL and HOLD; held at 0 in IDLE and TIMING.
  - tick = (prescaler == TICK_DIV-1).
- step_en, seq_clr, lights_out and jump_start are combinational decodes of registered state plus inputs.
- react_valid and react_time are registered.
- IDLE:
  - trigger=1: seq_clr=1 for that cycle; next state FILL; prescaler<=0; step_cnt<=0.
  - react is ignored.
- FILL:
  - step_en = tick. Each tick: step_cnt++.
  - First step_en falls in the TICK_DIV-th cycle after the trigger edge.
  - On the tick where step_cnt==7 (8th step): next state HOLD; delay_cnt <= lfsr.
- HOLD:
  - Each tick: delay_cnt--.
  - On the tick where delay_cnt==1: step_en=1 and lights_out=1 that cycle (light register wraps to 0x00); next state TIMING; react_cnt<=0.
  - Delay range: 1..2^LFSR_W-1 ticks.
- TIMING:
  - react_cnt increments every cycle and saturates at all-ones.
  - react=1: react_time<=react_cnt; react_valid=1 the following cycle; next state IDLE.
  - react held high at lights_out: react_time=0.
- trigger is ignored outside IDLE; there is no re-arm while busy.
- react held across the TIMING->IDLE transition has no further effect.
- Reset mid-sequence returns everything to reset values. The light register is cleared by its own reset, not by seq_clr.

Optional Feature:
- Macro: F1_JUMP_START_EN.
- Defined:
  - react=1 in FILL or HOLD aborts the sequence.
  - That cycle: jump_start=1 and seq_clr=1; next state IDLE; step_en suppressed.
  - react_time is unchanged and react_valid is not asserted.
  - If react coincides with the final HOLD tick, the jump start wins: no lights_out.
- Undefined:
  - react is ignored in FILL and HOLD; jump_start is tied 0.

Test Plan:
- Reset / idle: rst_n low then high, no trigger for 50 cycles -> busy=0, step_en never pulses, react_time=0.
- Fill pacing (TICK_DIV=4): trigger pulse at edge 0 -> seq_clr in that cycle. step_en pulses in cycles 3,7,...,31, exactly 8 pulses. Light register reads 0x01,0x03,...,0xFF.
- Hold and lights out:
  - Bench models the LFSR from reset to predict D.
  - Expect lights_out and a 9th step_en exactly 4*D cycles after the 8th step_en. Light register then reads 0x00.
  - Sweep 3 starts, including one with D=1.
- Reaction timing:
  - react asserted 37 cycles after lights_out -> react_time=37 with one react_valid pulse, then busy=0.
  - react held from lights_out -> react_time=0.
  - No react for 70000 cycles, then react -> react_time=0xFFFF.
- Jump start (macro defined): react during FILL after 3 steps -> jump_start and seq_clr pulse, no further step_en, react_time unchanged. Same stimulus with the macro undefined -> sequence completes normally.
- Async reset in HOLD: rst_n low mid-cycle -> busy drops immediately. A subsequent trigger gives a full normal 8-step sequence.
